// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with pending-write scoreboard.
// Same-cycle write-to-read bypass is built when RF_BYPASS_EN is defined.
module regfile_mp #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int N_REGS = 1 << IDX_W,
  parameter int N_RD   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr0_en,
  input  logic [IDX_W-1:0]        wr0_idx,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [IDX_W-1:0]        wr1_idx,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic [N_RD*IDX_W-1:0]   rd_idx,
  input  logic [N_RD-1:0]         rd_nobyp,
  output logic [N_RD*DATA_W-1:0]  rd_data,
  output logic [N_RD-1:0]         rd_pend,
  input  logic                    iss_en,
  input  logic [IDX_W-1:0]        iss_idx,
  output logic                    ready
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REGS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [N_REGS-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]  regs_q [N_REGS];

  logic run;
  logic w0_ok;
  logic w1_ok;
  logic iss_ok;

  // r0 is never stored or pended; indices past the array are inert
  function automatic logic idx_ok(input logic [IDX_W-1:0] i);
    return (i != '0) && (int'(i) < N_REGS);
  endfunction

  assign run    = (state_q == RUN);
  assign ready  = run;
  assign w0_ok  = run && wr0_en && idx_ok(wr0_idx);
  assign w1_ok  = run && wr1_en && idx_ok(wr1_idx);
  assign iss_ok = run && iss_en && idx_ok(iss_idx);

  // Clear sequencer: one register per cycle, then hand over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Scoreboard: writes retire a producer, a same-cycle issue re-arms it
  always_comb begin
    pend_d = pend_q;
    if (!run) begin
      pend_d = '0;
    end else begin
      if (w0_ok) pend_d[wr0_idx] = 1'b0;
      if (w1_ok) pend_d[wr1_idx] = 1'b0;
      if (iss_ok) pend_d[iss_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage array; contents are scrubbed by the clear walk, so no reset
  always_ff @(posedge clk) begin
    if (!run) begin
      regs_q[cnt_q] <= '0;
    end else begin
      if (w0_ok) regs_q[wr0_idx] <= wr0_data;
      if (w1_ok) regs_q[wr1_idx] <= wr1_data;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [IDX_W-1:0] ri;
    logic             vld;
    logic             hit0;
    logic             hit1;

    assign ri  = rd_idx[p*IDX_W +: IDX_W];
    assign vld = run && idx_ok(ri);

`ifdef RF_BYPASS_EN
    assign hit1 = w1_ok && (wr1_idx == ri) && !rd_nobyp[p];
    assign hit0 = w0_ok && (wr0_idx == ri) && !rd_nobyp[p];
`else
    assign hit1 = 1'b0;
    assign hit0 = 1'b0;
`endif

    assign rd_data[p*DATA_W +: DATA_W] =
      !vld ? '0 :
      hit1 ? wr1_data :
      hit0 ? wr0_data :
             regs_q[ri];

    assign rd_pend[p] = vld && !(hit0 || hit1) && pend_q[ri];
  end

`ifndef RF_BYPASS_EN
  logic unused_nobyp;
  assign unused_nobyp = ^rd_nobyp;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector bench for regfile_mp.
// Expected values follow RF_BYPASS_EN the same way the design build does.
module tb_regfile_mp;

  localparam int IDX_W  = 4;
  localparam int DATA_W = 32;
  localparam int N_REGS = 16;
  localparam int N_RD   = 2;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wr0_en = 1'b0;
  logic [IDX_W-1:0]       wr0_idx = '0;
  logic [DATA_W-1:0]      wr0_data = '0;
  logic                   wr1_en = 1'b0;
  logic [IDX_W-1:0]       wr1_idx = '0;
  logic [DATA_W-1:0]      wr1_data = '0;
  logic [N_RD*IDX_W-1:0]  rd_idx = '0;
  logic [N_RD-1:0]        rd_nobyp = '0;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_pend;
  logic                   iss_en = 1'b0;
  logic [IDX_W-1:0]       iss_idx = '0;
  logic                   ready;

  regfile_mp #(
    .IDX_W (IDX_W),
    .DATA_W(DATA_W),
    .N_REGS(N_REGS),
    .N_RD  (N_RD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr0_en  (wr0_en),
    .wr0_idx (wr0_idx),
    .wr0_data(wr0_data),
    .wr1_en  (wr1_en),
    .wr1_idx (wr1_idx),
    .wr1_data(wr1_data),
    .rd_idx  (rd_idx),
    .rd_nobyp(rd_nobyp),
    .rd_data (rd_data),
    .rd_pend (rd_pend),
    .iss_en  (iss_en),
    .iss_idx (iss_idx),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w0e;
    logic [3:0]  w0i;
    logic [31:0] w0d;
    logic        w1e;
    logic [3:0]  w1i;
    logic [31:0] w1d;
    logic        ie;
    logic [3:0]  ii;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [1:0]  nb;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        p0;
    logic        p1;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic w0e, input logic [3:0] w0i, input logic [31:0] w0d,
    input logic w1e, input logic [3:0] w1i, input logic [31:0] w1d,
    input logic ie, input logic [3:0] ii,
    input logic [3:0] r0, input logic [3:0] r1, input logic [1:0] nb,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic p0, input logic p1);
    vec_t v;
    v.w0e = w0e; v.w0i = w0i; v.w0d = w0d;
    v.w1e = w1e; v.w1i = w1i; v.w1d = w1d;
    v.ie = ie; v.ii = ii;
    v.r0 = r0; v.r1 = r1; v.nb = nb;
    v.e0 = e0; v.e1 = e1; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_idx = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_idx = '0; wr1_data = '0;
    iss_en = 1'b0; iss_idx = '0;
    rd_nobyp = '0;
  endtask

  task automatic read2(input logic [3:0] a, input logic [3:0] b);
    rd_idx = {b, a};
    #1;
  endtask

  // Walk the clear sequence from release: ready low for 15 edges, high at 16
  task automatic clear_walk(input string tag);
    chk({tag, ".ready0"}, 32'(ready), 32'd0);
    for (int k = 1; k <= N_REGS; k++) begin
      tick();
      if (k == N_REGS) idle();
      #1;
      chk($sformatf("%s.ready@%0d", tag, k), 32'(ready),
          (k == N_REGS) ? 32'd1 : 32'd0);
      if (k < N_REGS) begin
        chk($sformatf("%s.d0@%0d", tag, k), rd_data[31:0], 32'd0);
        chk($sformatf("%s.d1@%0d", tag, k), rd_data[63:32], 32'd0);
        chk($sformatf("%s.pend@%0d", tag, k), 32'(rd_pend), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(1,3,32'hDEADBEEF, 0,0,0, 0,0, 3,5,2'b00,
                      BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0,0));
    vecs.push_back(mk(1,5,32'h11, 1,5,32'h22, 0,0, 3,5,2'b00,
                      32'hDEADBEEF, BYP ? 32'h22 : 32'h0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 5,3,2'b00,
                      32'h22, 32'hDEADBEEF, 0,0));
    vecs.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0,2'b00,
                      32'h0, 32'h0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,2'b00,
                      32'h0, 32'h0, 0,0));
    vecs.push_back(mk(1,7,32'h1111, 0,0,0, 0,0, 1,2,2'b00,
                      32'h0, 32'h0, 0,0));
    vecs.push_back(mk(0,0,0, 1,7,32'hA5A5, 0,0, 3,7,2'b00,
                      32'hDEADBEEF, BYP ? 32'hA5A5 : 32'h1111, 0,0));
    vecs.push_back(mk(0,0,0, 1,7,32'hBBBB, 0,0, 7,7,2'b10,
                      BYP ? 32'hBBBB : 32'hA5A5, 32'hA5A5, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,7,2'b00,
                      32'hBBBB, 32'hBBBB, 0,0));
    vecs.push_back(mk(1,8,32'h8, 1,8,32'h9, 0,0, 8,8,2'b01,
                      32'h0, BYP ? 32'h9 : 32'h0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 8,8,2'b00,
                      32'h9, 32'h9, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9, 9,10,2'b00,
                      32'h0, 32'h0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,2'b00,
                      32'h0, 32'h0, 1,1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,2'b00,
                      32'h0, 32'h0, 1,1));
    vecs.push_back(mk(1,9,32'h99, 0,0,0, 0,0, 9,9,2'b10,
                      BYP ? 32'h99 : 32'h0, 32'h0, !BYP, 1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,2'b00,
                      32'h99, 32'h99, 0,0));
    vecs.push_back(mk(0,0,0, 1,9,32'hAB, 1,9, 9,9,2'b00,
                      BYP ? 32'hAB : 32'h99, BYP ? 32'hAB : 32'h99, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,2'b00,
                      32'hAB, 32'hAB, 1,1));
    vecs.push_back(mk(1,9,32'hCD, 0,0,0, 0,0, 9,9,2'b00,
                      BYP ? 32'hCD : 32'hAB, BYP ? 32'hCD : 32'hAB,
                      !BYP, !BYP));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 9,9,2'b00,
                      32'hCD, 32'hCD, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 10,9,2'b00,
                      32'h0, 32'hCD, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 10,9,2'b00,
                      32'h0, 32'hCD, 1,0));

    // Power-up clear with ignored write/issue traffic
    repeat (3) tick();
    chk("rst.ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    wr0_en = 1'b1; wr0_idx = 4'd3; wr0_data = 32'h1234;
    iss_en = 1'b1; iss_idx = 4'd4;
    rd_idx = {4'd4, 4'd3};
    clear_walk("clr");

    for (int r = 1; r < N_REGS; r++) begin
      read2(r[3:0], r[3:0]);
      chk($sformatf("post.r%0d", r), rd_data[31:0], 32'd0);
      chk($sformatf("post.p%0d", r), 32'(rd_pend), 32'd0);
    end

    foreach (vecs[i]) begin
      wr0_en = vecs[i].w0e; wr0_idx = vecs[i].w0i; wr0_data = vecs[i].w0d;
      wr1_en = vecs[i].w1e; wr1_idx = vecs[i].w1i; wr1_data = vecs[i].w1d;
      iss_en = vecs[i].ie;  iss_idx = vecs[i].ii;
      rd_idx = {vecs[i].r1, vecs[i].r0};
      rd_nobyp = vecs[i].nb;
      #1;
      chk($sformatf("v%0d.d0", i), rd_data[31:0], vecs[i].e0);
      chk($sformatf("v%0d.d1", i), rd_data[63:32], vecs[i].e1);
      chk($sformatf("v%0d.p0", i), 32'(rd_pend[0]), 32'(vecs[i].p0));
      chk($sformatf("v%0d.p1", i), 32'(rd_pend[1]), 32'(vecs[i].p1));
      tick();
    end
    idle();

    // Reset pulse mid-RUN while r10 is pending
    read2(4'd3, 4'd10);
    rst_n = 1'b0;
    #1;
    chk("mid.ready", 32'(ready), 32'd0);
    chk("mid.d0", rd_data[31:0], 32'd0);
    chk("mid.pend", 32'(rd_pend), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_walk("rerun");

    read2(4'd3, 4'd7);
    chk("rerun.r3", rd_data[31:0], 32'd0);
    chk("rerun.r7", rd_data[63:32], 32'd0);
    read2(4'd9, 4'd10);
    chk("rerun.r9", rd_data[31:0], 32'd0);
    chk("rerun.r10", rd_data[63:32], 32'd0);
    chk("rerun.pend", 32'(rd_pend), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
